// File: rtl/pc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_pkg : op encoding and op field width shared by the PC datapath     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package pc_pkg;

  localparam int PC_OP_W = 3;

  localparam logic [PC_OP_W-1:0] PC_OP_SEQ  = 3'd0;
  localparam logic [PC_OP_W-1:0] PC_OP_JMP  = 3'd1;
  localparam logic [PC_OP_W-1:0] PC_OP_BR   = 3'd2;
  localparam logic [PC_OP_W-1:0] PC_OP_CALL = 3'd3;
  localparam logic [PC_OP_W-1:0] PC_OP_RET  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_ret_stack : return-address LIFO with push, pop, full/empty and     |
// |                top-of-stack read                                      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pc_ret_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic [IDX_W-1:0]  w_top_idx;
  logic [IDX_W-1:0]  w_wr_idx;

  // r_sp counts occupied entries, so the top lives one slot below it
  assign w_top_idx = IDX_W'(r_sp - SP_W'(1));
  assign w_wr_idx  = IDX_W'(r_sp);
  assign full      = (r_sp == SP_W'(DEPTH));
  assign empty     = (r_sp == '0);
  assign top       = r_mem[w_top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (push && !full) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (pop && !empty) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_unit : registered program counter with SEQ/JMP/BR and optional     |
// |           CALL/RET return stack (enabled by PC_CALL_STACK_EN)         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                OFF_W       = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [PC_OP_W-1:0] op,
  input  logic               cond,
  input  logic [ADDR_W-1:0]  target,
  input  logic [OFF_W-1:0]   offset,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               redirect,
  output logic               stack_ovf,
  output logic               stack_unf
);

  logic [ADDR_W-1:0]       r_pc;
  logic                    r_redirect;
  logic [ADDR_W-1:0]       w_pc_plus1;
  logic [ADDR_W-1:0]       w_next_pc;
  logic [ADDR_W-1:0]       w_br_target;
  logic signed [OFF_W-1:0] w_offset_s;
  logic                    w_redirect;

  assign w_offset_s  = offset;
  assign w_pc_plus1  = r_pc + ADDR_W'(1);
  // size cast of a signed operand sign-extends the offset to ADDR_W
  assign w_br_target = r_pc + ADDR_W'(w_offset_s);

`ifdef PC_CALL_STACK_EN
  logic              w_push;
  logic              w_pop;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic [ADDR_W-1:0] w_stack_top;
  logic              w_stack_full;
  logic              w_stack_empty;
  logic              r_stack_ovf;
  logic              r_stack_unf;

  pc_ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push & ~stall),
    .pop       (w_pop & ~stall),
    .push_data (w_pc_plus1),
    .top       (w_stack_top),
    .full      (w_stack_full),
    .empty     (w_stack_empty)
  );
`endif

  always_comb begin
    w_next_pc  = w_pc_plus1;
    w_redirect = 1'b0;
`ifdef PC_CALL_STACK_EN
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_ovf_set  = 1'b0;
    w_unf_set  = 1'b0;
`endif
    case (op)
      PC_OP_JMP: begin
        w_next_pc  = target;
        w_redirect = 1'b1;
      end
      PC_OP_BR: begin
        if (cond) begin
          w_next_pc  = w_br_target;
          w_redirect = 1'b1;
        end
      end
      PC_OP_CALL: begin
        w_next_pc  = target;
        w_redirect = 1'b1;
`ifdef PC_CALL_STACK_EN
        // a full stack drops the return address but the jump still happens
        w_push     = ~w_stack_full;
        w_ovf_set  = w_stack_full;
`endif
      end
      PC_OP_RET: begin
`ifdef PC_CALL_STACK_EN
        if (w_stack_empty) begin
          w_unf_set = 1'b1;
        end else begin
          w_pop      = 1'b1;
          w_next_pc  = w_stack_top;
          w_redirect = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_VEC;
      r_redirect <= 1'b0;
    end else begin
      r_redirect <= w_redirect & ~stall;
      if (!stall) begin
        r_pc <= w_next_pc;
      end
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stack_ovf <= 1'b0;
      r_stack_unf <= 1'b0;
    end else if (!stall) begin
      r_stack_ovf <= r_stack_ovf | w_ovf_set;
      r_stack_unf <= r_stack_unf | w_unf_set;
    end
  end

  assign stack_ovf = r_stack_ovf;
  assign stack_unf = r_stack_unf;
`else
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

  assign pc       = r_pc;
  assign pc_plus1 = w_pc_plus1;
  assign redirect = r_redirect;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_unit : self-checking bench for pc_unit against a queue-based    |
// |              reference model (follows PC_CALL_STACK_EN if defined)    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_pc_unit;
  import pc_pkg::*;

  localparam int ADDR_W = 8;
  localparam int OFF_W  = 8;
  localparam int DEPTH  = 4;
  localparam int MASK   = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] RST_VEC = 8'h00;

  typedef struct {
    logic [2:0]        op;
    logic              cond;
    logic [ADDR_W-1:0] target;
    logic [OFF_W-1:0]  offset;
    logic              stall;
  } stim_t;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b0;
  logic              stall  = 1'b0;
  logic [2:0]        op     = 3'd0;
  logic              cond   = 1'b0;
  logic [ADDR_W-1:0] target = '0;
  logic [OFF_W-1:0]  offset = '0;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic              redirect;
  logic              stack_ovf;
  logic              stack_unf;

  int n_checks = 0;
  int n_fail   = 0;

  int m_pc;
  bit m_redir;
  bit m_ovf;
  bit m_unf;
  int m_stack[$];

  pc_unit #(
    .ADDR_W      (ADDR_W),
    .OFF_W       (OFF_W),
    .RESET_VEC   (RST_VEC),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .op        (op),
    .cond      (cond),
    .target    (target),
    .offset    (offset),
    .pc        (pc),
    .pc_plus1  (pc_plus1),
    .redirect  (redirect),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pc    = RST_VEC;
    m_redir = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_stack.delete();
  endtask

  // Next state from the architectural rules, using the inputs presented at the edge
  task automatic model_step();
    int soff;
    m_redir = 1'b0;
    if (stall) return;
    case (op)
      3'd1: begin m_pc = target; m_redir = 1'b1; end
      3'd2: begin
        if (cond) begin
          soff    = int'($signed(offset));
          m_pc    = (m_pc + soff) & MASK;
          m_redir = 1'b1;
        end else begin
          m_pc = (m_pc + 1) & MASK;
        end
      end
      3'd3: begin
`ifdef PC_CALL_STACK_EN
        if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) & MASK);
        else m_ovf = 1'b1;
`endif
        m_pc    = target;
        m_redir = 1'b1;
      end
      3'd4: begin
`ifdef PC_CALL_STACK_EN
        if (m_stack.size() > 0) begin
          m_pc    = m_stack.pop_back();
          m_redir = 1'b1;
        end else begin
          m_pc  = (m_pc + 1) & MASK;
          m_unf = 1'b1;
        end
`else
        m_pc = (m_pc + 1) & MASK;
`endif
      end
      default: m_pc = (m_pc + 1) & MASK;
    endcase
  endtask

  // Drive one cycle from posedge+1, advance the model at the edge, return at posedge+1
  task automatic apply(input stim_t s);
    op     = s.op;
    cond   = s.cond;
    target = s.target;
    offset = s.offset;
    stall  = s.stall;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [2*ADDR_W+2:0] exp_vec();
    int nx;
    nx = (m_pc + 1) & MASK;
    return {m_pc[ADDR_W-1:0], nx[ADDR_W-1:0], m_redir, m_ovf, m_unf};
  endfunction

  task automatic test_reset();
    stim_t s;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({pc, pc_plus1, redirect, stack_ovf, stack_unf} !== {8'h00, 8'h01, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: got %h/%h r%b o%b u%b want 00/01 r0 o0 u0", pc, pc_plus1, redirect, stack_ovf, stack_unf);
    end
    rst_n = 1'b1;
    model_reset();
    s = '{PC_OP_SEQ, 1'b0, 8'h00, 8'h00, 1'b0};
    for (int i = 1; i <= 3; i++) begin
      apply(s);
      n_checks++;
      if ({pc, redirect} !== {i[ADDR_W-1:0], 1'b0}) begin
        n_fail++;
        $display("FAIL reset_seq%0d: got pc=%h redirect=%b want pc=%h redirect=0", i, pc, redirect, i[ADDR_W-1:0]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({pc, redirect} !== {RST_VEC, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got pc=%h redirect=%b want pc=%h redirect=0", pc, redirect, RST_VEC);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    n_checks++;
    if ({pc, pc_plus1, redirect, stack_ovf, stack_unf} !== exp_vec()) begin
      n_fail++;
      $display("FAIL post_reset: got %h want %h", {pc, pc_plus1, redirect, stack_ovf, stack_unf}, exp_vec());
    end
  endtask

  task automatic test_wrap_branch();
    stim_t tbl[6] = '{
      '{PC_OP_JMP, 1'b0, 8'hFE, 8'h00, 1'b0},
      '{PC_OP_SEQ, 1'b0, 8'h00, 8'h00, 1'b0},
      '{PC_OP_SEQ, 1'b0, 8'h00, 8'h00, 1'b0},
      '{PC_OP_SEQ, 1'b0, 8'h00, 8'h00, 1'b0},
      '{PC_OP_SEQ, 1'b0, 8'h00, 8'h00, 1'b0},
      '{PC_OP_BR,  1'b1, 8'h00, 8'hFC, 1'b0}
    };
    logic [ADDR_W-1:0] want_pc[6] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'hFE};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      n_checks++;
      if ({pc, pc_plus1, redirect, stack_ovf, stack_unf} !== exp_vec() || pc !== want_pc[i]) begin
        n_fail++;
        $display("FAIL wrap_branch[%0d]: got %h want %h (pc %h)", i, {pc, pc_plus1, redirect, stack_ovf, stack_unf}, exp_vec(), want_pc[i]);
      end
    end
  endtask

  task automatic test_branch();
    stim_t tbl[5] = '{
      '{PC_OP_JMP, 1'b0, 8'h10, 8'h00, 1'b0},
      '{PC_OP_BR,  1'b0, 8'h00, 8'h55, 1'b0},
      '{PC_OP_JMP, 1'b0, 8'h80, 8'h00, 1'b0},
      '{PC_OP_BR,  1'b1, 8'h00, 8'h7F, 1'b0},
      '{PC_OP_BR,  1'b1, 8'h00, 8'h80, 1'b0}
    };
    foreach (tbl[i]) begin
      apply(tbl[i]);
      n_checks++;
      if ({pc, pc_plus1, redirect, stack_ovf, stack_unf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL branch[%0d]: got %h want %h", i, {pc, pc_plus1, redirect, stack_ovf, stack_unf}, exp_vec());
      end
    end
  endtask

  task automatic test_call_ret();
    stim_t tbl[14] = '{
      '{PC_OP_JMP,  1'b0, 8'h10, 8'h00, 1'b0},
      '{PC_OP_CALL, 1'b0, 8'h40, 8'h00, 1'b0},
      '{PC_OP_RET,  1'b0, 8'h00, 8'h00, 1'b0},
      '{PC_OP_CALL, 1'b0, 8'h20, 8'h00, 1'b0},
      '{PC_OP_CALL, 1'b0, 8'h30, 8'h00, 1'b0},
      '{PC_OP_CALL, 1'b0, 8'h50, 8'h00, 1'b0},
      '{PC_OP_CALL, 1'b0, 8'h60, 8'h00, 1'b0},
      '{PC_OP_CALL, 1'b0, 8'h70, 8'h00, 1'b0},
      '{PC_OP_RET,  1'b0, 8'h00, 8'h00, 1'b0},
      '{PC_OP_RET,  1'b0, 8'h00, 8'h00, 1'b0},
      '{PC_OP_RET,  1'b0, 8'h00, 8'h00, 1'b0},
      '{PC_OP_RET,  1'b0, 8'h00, 8'h00, 1'b0},
      '{PC_OP_RET,  1'b0, 8'h00, 8'h00, 1'b0},
      '{PC_OP_SEQ,  1'b0, 8'h00, 8'h00, 1'b0}
    };
    foreach (tbl[i]) begin
      apply(tbl[i]);
      n_checks++;
      if ({pc, pc_plus1, redirect, stack_ovf, stack_unf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL call_ret[%0d]: got %h want %h", i, {pc, pc_plus1, redirect, stack_ovf, stack_unf}, exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    stim_t tbl[8] = '{
      '{PC_OP_JMP,  1'b0, 8'h10, 8'h00, 1'b0},
      '{PC_OP_JMP,  1'b0, 8'h55, 8'h00, 1'b1},
      '{PC_OP_JMP,  1'b0, 8'h55, 8'h00, 1'b1},
      '{PC_OP_JMP,  1'b0, 8'h55, 8'h00, 1'b1},
      '{PC_OP_JMP,  1'b0, 8'h55, 8'h00, 1'b0},
      '{PC_OP_CALL, 1'b0, 8'h33, 8'h00, 1'b1},
      '{PC_OP_RET,  1'b0, 8'h00, 8'h00, 1'b1},
      '{PC_OP_RET,  1'b0, 8'h00, 8'h00, 1'b0}
    };
    foreach (tbl[i]) begin
      apply(tbl[i]);
      n_checks++;
      if ({pc, pc_plus1, redirect, stack_ovf, stack_unf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall[%0d]: got %h want %h", i, {pc, pc_plus1, redirect, stack_ovf, stack_unf}, exp_vec());
      end
    end
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    stim_t s;
    pulse_reset();
    for (int i = 0; i < 24; i++) begin
      s.op     = ($urandom_range(0, 2) == 0) ? PC_OP_RET : ((i % 2 == 0) ? PC_OP_CALL : PC_OP_RET);
      s.cond   = 1'b0;
      s.target = 8'($urandom);
      s.offset = 8'h00;
      s.stall  = 1'b0;
      apply(s);
      n_checks++;
      if ({pc, pc_plus1, redirect, stack_ovf, stack_unf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, {pc, pc_plus1, redirect, stack_ovf, stack_unf}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      s.op     = 3'($urandom_range(0, 7));
      s.cond   = 1'($urandom);
      s.target = 8'($urandom);
      s.offset = 8'($urandom);
      s.stall  = ($urandom_range(0, 7) == 0);
      apply(s);
      n_checks++;
      if ({pc, pc_plus1, redirect, stack_ovf, stack_unf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: op=%0d got %h want %h", i, s.op, {pc, pc_plus1, redirect, stack_ovf, stack_unf}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_branch();
    test_branch();
    test_call_ret();
    test_stall();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised sequential program counter for the single-cycle CPU, replacing the pass-through address stage between next-address selection and the ALU / instruction memory. It holds the current PC in a register and computes the next PC from a small opcode: sequential, absolute jump, conditional relative branch, and optionally call/return via an internal return-address stack. It supports stall and provides sticky error flags for stack misuse.

## Interface
Parameters:
- ADDR_W, 8, PC / address width in bits
- OFF_W, 8, signed relative-branch offset width (OFF_W <= ADDR_W)
- RESET_VEC, 0, PC value loaded on reset
- STACK_DEPTH, 4, return-address stack entries (power of two, >= 2)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- stall  input  1  hold PC and stack unchanged this cycle
- op  input  3  next-PC operation: SEQ=0, JMP=1, BR=2, CALL=3, RET=4; 5..7 treated as SEQ
- cond  input  1  branch condition, used only by BR
- target  input  ADDR_W  absolute target for JMP / CALL
- offset  input  OFF_W  signed offset for BR, relative to current pc
- pc  output  ADDR_W  registered current PC, to instruction memory and ALU
- pc_plus1  output  ADDR_W  combinational pc + 1
- redirect  output  1  registered; 1 in the cycle after a non-sequential PC update
- stack_ovf  output  1  sticky: CALL issued while the stack was full
- stack_unf  output  1  sticky: RET issued while the stack was empty

## Operation
- Reset (asynchronous, rst_n=0): pc=RESET_VEC, redirect=0, stack pointer=0, stack_ovf=0, stack_unf=0. Stack contents are don't-care. Reset asserted mid-operation overrides everything immediately.
- Each rising edge with stall=0 updates pc as follows:
  - SEQ: pc <= pc+1.
  - JMP: pc <= target.
  - BR: if cond=1, pc <= pc + sign_extend(offset); otherwise pc <= pc+1.
  - CALL: push pc+1, then pc <= target.
  - RET: pop, then pc <= popped value.
- All arithmetic is modulo 2^ADDR_W. pc=2^ADDR_W-1 with SEQ wraps to 0. Negative offsets wrap below 0.
- redirect <= 1 when the update was JMP, a taken BR, CALL, or a successful RET; otherwise 0.
- Stack boundary cases:
  - CALL on a full stack: the jump still occurs, the push is dropped, and stack_ovf is set.
  - RET on an empty stack: pc <= pc+1, redirect=0, and stack_unf is set.
- Error flags are cleared only by reset.
- stall=1: pc, stack, stack pointer and flags hold; redirect <= 0. Stall dominates any op.

## Timing
- pc changes only on the rising clk edge; new pc is visible one cycle after op is presented.
- pc_plus1 is combinational from pc, with zero latency.
- redirect is valid in the same cycle as the new pc.
- Back-to-back CALL/RET on consecutive cycles are fully supported, with no bubbles.
- No input-to-output combinational path except pc to pc_plus1.

## Configuration
- PC_CALL_STACK_EN defined: return-address stack, CALL/RET semantics and stack_ovf/stack_unf as described above.
- PC_CALL_STACK_EN undefined: no stack storage is built and STACK_DEPTH is ignored. CALL behaves exactly as JMP and RET behaves exactly as SEQ. stack_ovf and stack_unf are tied to 0.

## Structure
- Shared package pc_pkg holds:
  - the op encoding constants (PC_OP_SEQ, PC_OP_JMP, PC_OP_BR, PC_OP_CALL, PC_OP_RET)
  - the op field width (3)
- Decode logic and the control unit both use pc_pkg.
- One sub-module, pc_ret_stack: a LIFO with push, pop, full, empty and a top-of-stack read. It is instantiated only under PC_CALL_STACK_EN.

## Test plan
- Reset, then 3 cycles of SEQ: pc = 0x00, 0x01, 0x02, 0x03; redirect=0 throughout. Assert rst_n=0 mid-stream: pc=0x00 immediately, without waiting for a clock.
- pc=0xFE, SEQ twice: pc = 0xFF, then 0x00 (wrap). Then BR with cond=1 and offset=0xFC (-4) from pc=0x02: pc=0xFE, redirect=1.
- BR with cond=0 from pc=0x10: pc=0x11, redirect=0. JMP with target=0x80: pc=0x80, redirect=1.
- STACK_DEPTH=4:
  - CALL with target=0x40 from pc=0x10, then RET: pc=0x40, then 0x11.
  - 5 nested CALLs: the 5th jumps and sets stack_ovf=1. Then 4 RETs return correctly, and a 5th RET sets stack_unf=1 with pc advancing by +1.
- stall=1 held 3 cycles with op=JMP and target=0x55: pc unchanged, redirect=0. On stall release, pc=0x55 on the next edge.
- Build without PC_CALL_STACK_EN: CALL with target=0x20 gives pc=0x20. RET gives pc+1. stack_ovf and stack_unf remain 0.
